// File: rtl/wide_adder_pipe_if.sv
// Operand/result beat bundle for wide_adder_pipe: valid/ready input side, valid/ready output side.
// master drives operands and out_ready; slave is the adder.
interface wide_adder_pipe_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din_one;
  logic [WIDTH-1:0] din_two;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             zero;

  modport master (
    output in_valid, din_one, din_two, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, zero
  );

  modport slave (
    input  in_valid, din_one, din_two, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, zero
  );
endinterface

// File: rtl/wide_adder_pipe.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage; latency STAGES cycles, 1 beat/clk.
// Backpressure: the whole pipeline freezes while out_valid && !out_ready, and in_ready is low on exactly those cycles.
module wide_adder_pipe #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input logic              clk,
  input logic              rst,
  wide_adder_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic             stall;
  logic             stg_vld [STAGES];
  logic             stg_cry [STAGES];
  logic             stg_sub [STAGES];
  logic [WIDTH-1:0] stg_a   [STAGES];
  logic [WIDTH-1:0] stg_b   [STAGES];
  logic [WIDTH-1:0] stg_res [STAGES];
  logic             zero_q;

  assign stall         = stg_vld[STAGES-1] && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = stg_vld[STAGES-1];
  assign bus.sum       = stg_res[STAGES-1];
  assign bus.cout      = stg_cry[STAGES-1];
  assign bus.zero      = zero_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic             c_in;
    logic             s_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] r_nxt;
    logic [CHUNK:0]   slice;

    if (k == 0) begin : g_head
      // Subtract is A + ~B + ~cin, so the stage-0 carry is cin flipped by sub.
      assign v_in = bus.in_valid;
      assign a_in = bus.din_one;
      assign b_in = bus.din_two;
      assign s_in = bus.sub;
      assign c_in = bus.cin ^ bus.sub;
      assign r_in = '0;
    end else begin : g_body
      assign v_in = stg_vld[k-1];
      assign a_in = stg_a[k-1];
      assign b_in = stg_b[k-1];
      assign s_in = stg_sub[k-1];
      assign c_in = stg_cry[k-1];
      assign r_in = stg_res[k-1];
    end

    assign slice = {1'b0, a_in[k*CHUNK +: CHUNK]}
                 + {1'b0, b_in[k*CHUNK +: CHUNK] ^ {CHUNK{s_in}}}
                 + {{CHUNK{1'b0}}, c_in};

    always_comb begin
      r_nxt                    = r_in;
      r_nxt[k*CHUNK +: CHUNK]  = slice[CHUNK-1:0];
    end

    // Data registers load only with a real beat, so bubbles never disturb held results.
    always_ff @(posedge clk) begin
      if (rst) begin
        stg_vld[k] <= 1'b0;
        stg_cry[k] <= 1'b0;
        stg_sub[k] <= 1'b0;
        stg_a[k]   <= '0;
        stg_b[k]   <= '0;
        stg_res[k] <= '0;
      end else if (!stall) begin
        stg_vld[k] <= v_in;
        if (v_in) begin
          stg_cry[k] <= slice[CHUNK];
          stg_sub[k] <= s_in;
          stg_a[k]   <= a_in;
          stg_b[k]   <= b_in;
          stg_res[k] <= r_nxt;
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) begin
          zero_q <= 1'b0;
        end else if (!stall && v_in) begin
          zero_q <= (r_nxt == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_wide_adder_pipe.sv
// Scoreboard bench for wide_adder_pipe at 128/32, 256/64 and 64/64; one selected instance is driven at a time.
module tb_wide_adder_pipe;
  typedef struct packed {
    logic [255:0] sum;
    logic         cout;
    logic         zero;
  } exp_t;

  typedef struct packed {
    logic [127:0] a;
    logic [127:0] b;
    logic         cin;
    logic         sub;
    logic [127:0] sum;
    logic         cout;
    logic         zero;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         cin;
  logic         sub;
  logic         out_ready;
  logic [255:0] a;
  logic [255:0] b;
  int           sel;

  logic [255:0] o_sum;
  logic         o_cout;
  logic         o_zero;
  logic         o_valid;
  logic         o_in_ready;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  wide_adder_pipe_if #(.WIDTH(128)) if_a ();
  wide_adder_pipe_if #(.WIDTH(256)) if_b ();
  wide_adder_pipe_if #(.WIDTH(64))  if_c ();

  wide_adder_pipe #(.WIDTH(128), .CHUNK(32)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  wide_adder_pipe #(.WIDTH(256), .CHUNK(64)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
  wide_adder_pipe #(.WIDTH(64),  .CHUNK(64)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.in_valid  = in_valid && (sel == 0);
  assign if_a.din_one   = a[127:0];
  assign if_a.din_two   = b[127:0];
  assign if_a.cin       = cin;
  assign if_a.sub       = sub;
  assign if_a.out_ready = (sel == 0) ? out_ready : 1'b1;

  assign if_b.in_valid  = in_valid && (sel == 1);
  assign if_b.din_one   = a;
  assign if_b.din_two   = b;
  assign if_b.cin       = cin;
  assign if_b.sub       = sub;
  assign if_b.out_ready = (sel == 1) ? out_ready : 1'b1;

  assign if_c.in_valid  = in_valid && (sel == 2);
  assign if_c.din_one   = a[63:0];
  assign if_c.din_two   = b[63:0];
  assign if_c.cin       = cin;
  assign if_c.sub       = sub;
  assign if_c.out_ready = (sel == 2) ? out_ready : 1'b1;

  always_comb begin
    o_sum      = '0;
    o_cout     = 1'b0;
    o_zero     = 1'b0;
    o_valid    = 1'b0;
    o_in_ready = 1'b0;
    case (sel)
      0: begin
        o_sum = {128'd0, if_a.sum}; o_cout = if_a.cout; o_zero = if_a.zero;
        o_valid = if_a.out_valid; o_in_ready = if_a.in_ready;
      end
      1: begin
        o_sum = if_b.sum; o_cout = if_b.cout; o_zero = if_b.zero;
        o_valid = if_b.out_valid; o_in_ready = if_b.in_ready;
      end
      default: begin
        o_sum = {192'd0, if_c.sum}; o_cout = if_c.cout; o_zero = if_c.zero;
        o_valid = if_c.out_valid; o_in_ready = if_c.in_ready;
      end
    endcase
  end

  // Reference: exact arithmetic at w bits; subtract borrow derived by magnitude comparison.
  function automatic exp_t model(input logic [255:0] x, input logic [255:0] y,
                                 input logic c, input logic s, input int w);
    exp_t         r;
    logic [256:0] full;
    logic [255:0] m;
    m = (w == 256) ? {256{1'b1}} : ((256'd1 << w) - 256'd1);
    x = x & m;
    y = y & m;
    if (!s) begin
      full   = {1'b0, x} + {1'b0, y} + {256'd0, c};
      r.cout = full[w];
    end else begin
      full   = {1'b0, x} - {1'b0, y} - {256'd0, c};
      r.cout = ({1'b0, x} >= ({1'b0, y} + {256'd0, c}));
    end
    r.sum  = full[255:0] & m;
    r.zero = (r.sum == 256'd0);
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; sel = 0;
    a = rand256(); b = rand256(); cin = 1'b1; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_cmp++;
      if (o_valid !== 1'b0) begin
        n_bad++; $display("FAIL reset_out_valid dut%0d: got %b want 0", s, o_valid);
      end
      n_cmp++;
      if (o_in_ready !== 1'b1) begin
        n_bad++; $display("FAIL reset_in_ready dut%0d: got %b want 1", s, o_in_ready);
      end
    end
    in_valid = 1'b0; rst = 1'b0; sel = 0;
    tick();
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_cmp++;
      if ({o_valid, o_cout, o_zero, o_sum} !== 259'd0) begin
        n_bad++;
        $display("FAIL post_reset_outputs dut%0d: got valid=%b cout=%b zero=%b sum=%h want all 0", s, o_valid, o_cout, o_zero, o_sum);
      end
    end
    sel = 0;
  endtask

  task automatic test_directed();
    vec_t tv [5];
    int   n;
    tv[0] = '{a: {128{1'b1}}, b: 128'd0, cin: 1'b1, sub: 1'b0, sum: 128'd0, cout: 1'b1, zero: 1'b1};
    tv[1] = '{a: 128'd0, b: 128'd1, cin: 1'b0, sub: 1'b1, sum: {128{1'b1}}, cout: 1'b0, zero: 1'b0};
    tv[2] = '{a: 128'd5, b: 128'd5, cin: 1'b0, sub: 1'b1, sum: 128'd0, cout: 1'b1, zero: 1'b1};
    tv[3] = '{a: 128'h00000000_FFFFFFFF_00000000_FFFFFFFF, b: 128'h00000000_00000001_00000000_00000001,
              cin: 1'b0, sub: 1'b0, sum: 128'h00000001_00000000_00000001_00000000, cout: 1'b0, zero: 1'b0};
    tv[4] = '{a: {128{1'b1}}, b: {128{1'b1}}, cin: 1'b1, sub: 1'b0, sum: {128{1'b1}}, cout: 1'b1, zero: 1'b0};
    sel = 0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = {128'd0, tv[i].a}; b = {128'd0, tv[i].b}; cin = tv[i].cin; sub = tv[i].sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (o_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      n_cmp++;
      if (n !== 4) begin
        n_bad++; $display("FAIL directed_latency vec%0d: got %0d cycles want 4", i, n);
      end
      n_cmp++;
      if ({o_sum, o_cout, o_zero} !== {128'd0, tv[i].sum, tv[i].cout, tv[i].zero}) begin
        n_bad++;
        $display("FAIL directed_result vec%0d: got sum=%h cout=%b zero=%b want sum=%h cout=%b zero=%b", i, o_sum[127:0], o_cout, o_zero, tv[i].sum, tv[i].cout, tv[i].zero);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back(input int s, input int w);
    int           pat [6] = '{1, 1, 0, 0, 1, 0};
    int           sent;
    int           got;
    int           cyc;
    bit           need_new;
    bit           was_stall;
    logic [258:0] held;
    exp_t         e;
    sel = s; sbq.delete();
    sent = 0; got = 0; cyc = 0; need_new = 1'b1; was_stall = 1'b0; held = '0;
    while ((sent < 16 || got < 16) && cyc < 400) begin
      out_ready = (pat[cyc % 6] != 0);
      if (need_new && sent < 16) begin
        a = rand256(); b = rand256(); cin = $urandom_range(0, 1) != 0; sub = $urandom_range(0, 1) != 0;
        if (sent % 5 == 0) begin b = ~a; cin = 1'b1; sub = 1'b0; end
        if (sent % 7 == 3) begin b = a;  cin = 1'b0; sub = 1'b1; end
        need_new = 1'b0;
      end
      in_valid = (sent < 16);
      #1;
      n_cmp++;
      if (o_in_ready !== !(o_valid && !out_ready)) begin
        n_bad++; $display("FAIL b2b_in_ready dut%0d cyc%0d: got %b with out_valid=%b out_ready=%b", s, cyc, o_in_ready, o_valid, out_ready);
      end
      if (was_stall) begin
        n_cmp++;
        if ({o_valid, o_cout, o_zero, o_sum} !== held) begin
          n_bad++; $display("FAIL b2b_stall_hold dut%0d cyc%0d: got sum=%h want held sum=%h", s, cyc, o_sum, held[255:0]);
        end
      end
      if (o_valid && out_ready) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra_beat dut%0d cyc%0d: got sum=%h want no beat", s, cyc, o_sum);
        end else begin
          e = sbq.pop_front();
          if ({o_sum, o_cout, o_zero} !== e) begin
            n_bad++;
            $display("FAIL b2b_result dut%0d beat%0d: got sum=%h cout=%b zero=%b want sum=%h cout=%b zero=%b", s, got, o_sum, o_cout, o_zero, e.sum, e.cout, e.zero);
          end
        end
        got++;
      end
      was_stall = o_valid && !out_ready;
      held      = {o_valid, o_cout, o_zero, o_sum};
      if (in_valid && o_in_ready) begin
        sbq.push_back(model(a, b, cin, sub, w));
        sent++;
        need_new = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (got !== 16 || sbq.size() !== 0) begin
      n_bad++; $display("FAIL b2b_count dut%0d: got %0d beats out with %0d left pending want 16 and 0", s, got, sbq.size());
    end
    repeat (6) begin
      tick();
      n_cmp++;
      if (o_valid !== 1'b0) begin
        n_bad++; $display("FAIL b2b_trailing_valid dut%0d: got out_valid=%b want 0", s, o_valid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int   n;
    sel = 0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rand256(); b = rand256(); cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      rst = (i == 2);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({o_valid, o_cout, o_zero, o_sum} !== 259'd0) begin
        n_bad++; $display("FAIL midreset_quiet cyc%0d: got valid=%b sum=%h want all 0", i, o_valid, o_sum);
      end
      tick();
    end
    a = rand256(); b = rand256(); cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    e = model(a, b, cin, sub, 128);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (o_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 4) begin
      n_bad++; $display("FAIL midreset_latency: got %0d cycles want 4", n);
    end
    n_cmp++;
    if ({o_sum, o_cout, o_zero} !== e) begin
      n_bad++; $display("FAIL midreset_result: got sum=%h cout=%b want sum=%h cout=%b", o_sum, o_cout, e.sum, e.cout);
    end
    tick();
  endtask

  task automatic test_param_sweep();
    int w;
    int lat;
    int n;
    for (int s = 1; s < 3; s++) begin
      w   = (s == 1) ? 256 : 64;
      lat = (s == 1) ? 4 : 1;
      sel = s; out_ready = 1'b1;
      a = {256{1'b1}}; b = 256'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (o_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      n_cmp++;
      if (n !== lat) begin
        n_bad++; $display("FAIL sweep_latency w%0d: got %0d cycles want %0d", w, n, lat);
      end
      n_cmp++;
      if ({o_sum, o_cout, o_zero} !== {256'd0, 1'b1, 1'b1}) begin
        n_bad++; $display("FAIL sweep_wrap w%0d: got sum=%h cout=%b zero=%b want sum=0 cout=1 zero=1", w, o_sum, o_cout, o_zero);
      end
      tick();
      test_back_to_back(s, w);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(0, 128);
    test_reset_midflight();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wide_adder_pipe.md
Name: wide_adder_pipe

Overview:
- Parametrised, pipelined multi-word adder/subtractor; successor to the fixed 128-bit two-chunk adder used by the kara128 datapath.
- Splits WIDTH-bit operands into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. This gives a throughput of one operation per clock at any width.
- Has a valid/ready handshake on both sides, an add/sub mode, and a registered zero flag that replaces the old combinational "done".

Parameters:
- WIDTH, 128, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 32, bits added per pipeline stage; STAGES = WIDTH/CHUNK (≥1).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- din_one  in  WIDTH  operand A.
- din_two  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (add) / no-borrow flag (sub).
- zero  out  1  1 when sum == 0 for this beat.

Behaviour:
- Interface: one clock domain (clk); reset rst is synchronous and active-high.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Arithmetic per beat:
  - sub=0: {cout,sum} = A + B + cin.
  - sub=1: {cout,sum} = A + ~B + ~cin, i.e. A − B − cin. cout=1 means no borrow.
  - All widths are exact; nothing is truncated except by the WIDTH+1 result.
- Pipeline:
  - Stage k (0..STAGES-1) adds slice k of A and B (B inverted if sub) with the carry from stage k−1. Stage 0 carry-in is cin (add) or ~cin (sub).
  - Upper operand slices and the sub bit are skew-registered alongside. Lower result slices are carried forward.
- Latency: STAGES cycles from input transfer to out_valid, with no stall. Default is 4.
- Throughput: 1 beat/clk when out_ready is held high.
- Stall: the whole pipeline freezes when out_valid && !out_ready; in_ready = !(out_valid && !out_ready).
  - While stalled, every stage register, sum, cout and zero hold their values.
  - Input is not accepted while stalled.
- Bubbles: each stage carries a valid bit. Bubbles propagate and never produce out_valid.
- Outputs: sum, cout and zero are registered outputs of the final stage. zero is computed from the full WIDTH result, registered with it, and updated only when the final stage loads.
- Reset:
  - Every stage valid bit, out_valid, sum, cout and zero go to 0; in_ready=1 during and after reset.
  - Reset mid-operation discards all in-flight beats; no partial result is ever emitted.
- Boundary cases:
  - STAGES=1 degenerates to a single registered adder with latency 1.
  - All-ones + 1 wraps to sum=0, cout=1, zero=1.
  - A simultaneous output transfer and input transfer in the same cycle is legal and must not lose or duplicate beats.

Test Plan:
- Carry ripple across all chunks: A=2^128−1, B=0, cin=1, sub=0 → after 4 clk: sum=0, cout=1, zero=1.
- Subtract with borrow: A=0, B=1, cin=0, sub=1 → sum=2^128−1, cout=0, zero=0. Then A=5, B=5, cin=0 → sum=0, cout=1, zero=1.
- Chunk-boundary carries: A=0x00000000_FFFFFFFF_00000000_FFFFFFFF, B=1 at both 32-bit boundaries → correct per-chunk carry propagation; compare against a 129-bit reference model.
- Back-to-back plus backpressure:
  - Stimulus: 16 random beats, in_valid=1 every cycle; out_ready toggles with pattern 1,1,0,0,1,0.
  - Required: every result matches the model, in order; no loss or duplication; in_ready=0 exactly on stalled cycles; outputs stable while stalled.
- Reset mid-flight: issue 3 beats, assert rst for 1 cycle at cycle 2 → out_valid stays 0 afterwards, outputs are 0, and a new beat issued after reset emits normally at latency 4.
- Parameter sweep: rerun the random checks with WIDTH=256/CHUNK=64 (latency 4) and WIDTH=64/CHUNK=64 (latency 1) → all results match the model.
